// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
// thread_scheduler: round-robin issue-slot arbiter over hardware thread contexts
// Revision: 1.0
// ============================================================================
module thread_scheduler #(
    parameter  int NUM_THREADS = 4,
    parameter  int PC_W        = 32,
    parameter  int QUANTUM     = 8,
    localparam int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   launch_valid,
    input  logic [TID_W-1:0]       launch_tid,
    input  logic [PC_W-1:0]        launch_pc,
    input  logic                   done_valid,
    input  logic [TID_W-1:0]       done_tid,
    input  logic                   block_valid,
    input  logic [TID_W-1:0]       block_tid,
    input  logic                   wake_valid,
    input  logic [TID_W-1:0]       wake_tid,
    output logic                   issue_valid,
    output logic [TID_W-1:0]       issue_tid,
    output logic [PC_W-1:0]        issue_pc,
    input  logic                   issue_ready,
    output logic [NUM_THREADS-1:0] thread_busy,
    output logic                   err
);

    localparam int             c_QCNT_W = $clog2(QUANTUM + 1);
    localparam [c_QCNT_W-1:0]  c_QMAX   = c_QCNT_W'(QUANTUM);
    localparam [c_QCNT_W-1:0]  c_QONE   = c_QCNT_W'(1);
    localparam [TID_W-1:0]     c_TONE   = TID_W'(1);

    typedef enum logic [1:0] {
        ST_FREE    = 2'b00,
        ST_READY   = 2'b01,
        ST_BLOCKED = 2'b10
    } state_t;

    state_t              r_state [NUM_THREADS];
    logic [PC_W-1:0]     r_pc    [NUM_THREADS];
    logic [TID_W-1:0]    r_rr;
    logic [c_QCNT_W-1:0] r_qcount;

    state_t                 w_state_nxt [NUM_THREADS];
    logic [PC_W-1:0]        w_pc_nxt    [NUM_THREADS];
    logic [NUM_THREADS-1:0] w_ready_nxt;
    logic [NUM_THREADS-1:0] w_busy_nxt;
    logic                   w_err;

    logic                   w_accept;
    logic                   w_keep;
    logic [c_QCNT_W-1:0]    w_qinc;
    logic [c_QCNT_W-1:0]    w_qnxt;
    logic [TID_W-1:0]       w_start;
    logic [TID_W-1:0]       w_idx;
    logic [TID_W-1:0]       w_pick;
    logic                   w_found;
    logic                   w_nvalid;
    logic [TID_W-1:0]       w_ntid;

    // Only the highest-priority event per thread is evaluated; it is either
    // applied or flagged as illegal, lower-priority events are dropped silently.
    always_comb begin
        w_err       = 1'b0;
        w_ready_nxt = '0;
        w_busy_nxt  = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_state_nxt[t] = r_state[t];
            w_pc_nxt[t]    = r_pc[t];
            if (done_valid && (done_tid == TID_W'(t))) begin
                if (r_state[t] != ST_FREE) w_state_nxt[t] = ST_FREE;
                else                       w_err          = 1'b1;
            end else if (block_valid && (block_tid == TID_W'(t))) begin
                if (r_state[t] == ST_READY) w_state_nxt[t] = ST_BLOCKED;
                else                        w_err          = 1'b1;
            end else if (wake_valid && (wake_tid == TID_W'(t))) begin
                if (r_state[t] == ST_BLOCKED) w_state_nxt[t] = ST_READY;
                else                          w_err          = 1'b1;
            end else if (launch_valid && (launch_tid == TID_W'(t))) begin
                if (r_state[t] == ST_FREE) begin
                    w_state_nxt[t] = ST_READY;
                    w_pc_nxt[t]    = launch_pc;
                end else begin
                    w_err = 1'b1;
                end
            end
            w_ready_nxt[t] = (w_state_nxt[t] == ST_READY);
            w_busy_nxt[t]  = (w_state_nxt[t] != ST_FREE);
        end
    end

    // Grant selection on post-event state; the search visits the current
    // grant last so another READY thread always wins a rotation.
    always_comb begin
        w_accept = issue_valid && issue_ready;
        w_qinc   = r_qcount + c_QONE;
        w_keep   = issue_valid && w_ready_nxt[issue_tid] &&
                   (!w_accept || (w_qinc < c_QMAX));
        w_start  = issue_valid ? (issue_tid + c_TONE) : r_rr;
        w_found  = 1'b0;
        w_pick   = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_idx = w_start + TID_W'(i);
            if (!w_found && w_ready_nxt[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
        if (w_keep) begin
            w_nvalid = 1'b1;
            w_ntid   = issue_tid;
        end else begin
            w_nvalid = w_found;
            w_ntid   = w_pick;
        end
        if (w_nvalid && issue_valid && (w_ntid == issue_tid)) begin
            if (w_accept) w_qnxt = (w_qinc >= c_QMAX) ? '0 : w_qinc;
            else          w_qnxt = r_qcount;
        end else begin
            w_qnxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_state[t] <= ST_FREE;
                r_pc[t]    <= '0;
            end
            r_rr        <= '0;
            r_qcount    <= '0;
            issue_valid <= 1'b0;
            issue_tid   <= '0;
            issue_pc    <= '0;
            thread_busy <= '0;
            err         <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_state[t] <= w_state_nxt[t];
                r_pc[t]    <= w_pc_nxt[t];
            end
            r_qcount    <= w_qnxt;
            issue_valid <= w_nvalid;
            thread_busy <= w_busy_nxt;
            err         <= w_err;
            if (w_nvalid) begin
                r_rr      <= w_ntid + c_TONE;
                issue_tid <= w_ntid;
                issue_pc  <= w_pc_nxt[w_ntid];
            end else begin
                issue_pc  <= '0;
            end
        end
    end

endmodule
`default_nettype wire
